// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the fetch FSM state encoding and the default word size.
package fetch_pkg;

  localparam int unsigned WordSizeDefault = 16;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StDiscard = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO holding {inst, pc} pairs.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   push_i, wdata_i     write one entry at the tail
//   pop_i               drop the head entry
//   flush_i             empty the queue (wins over push/pop)
//   rdata_o             head entry (undefined when empty)
//   count_o             valid entries
//   full_o, empty_o     occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: issues one outstanding word read at a time,
// buffers responses with their PCs in a DEPTH-entry queue and hands them to
// decode with a valid/ready handshake. A redirect flushes the queue and
// restarts fetch; a read already in flight is drained in StDiscard.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   readM, address              memory read request / address
//   data, inputReady            memory response
//   inst, inst_pc, inst_valid   queue head to decode
//   inst_ready                  decode accepts head
//   redirect, redirect_pc       flush and restart fetch
//   num_inst                    accepted instruction count (wraps)
//   occupancy                   valid queue entries
// Build option: define INST_FETCH_BYPASS_EN to forward a response straight
// to decode in the same cycle when the queue is empty.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = WordSizeDefault,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       readM,
  output logic [WORD_SIZE-1:0]       address,
  input  logic [WORD_SIZE-1:0]       data,
  input  logic                       inputReady,
  output logic [WORD_SIZE-1:0]       inst,
  output logic [WORD_SIZE-1:0]       inst_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  input  logic                       redirect,
  input  logic [WORD_SIZE-1:0]       redirect_pc,
  output logic [WORD_SIZE-1:0]       num_inst,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned    CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_state_e         state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_SIZE-1:0] req_pc_q, req_pc_d;
  logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

  logic                   q_push, q_pop, q_full, q_empty;
  logic [2*WORD_SIZE-1:0] q_rdata;
  logic [CntW-1:0]        q_count, occ_next;
  logic                   resp_ok, take, bypass_vld;

  fetch_queue #(
    .Width (2 * WORD_SIZE),
    .Depth (DEPTH)
  ) u_queue (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (q_push),
    .wdata_i ({data, req_pc_q}),
    .pop_i   (q_pop),
    .flush_i (redirect),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // A response that will actually be kept (not stale, not overridden).
  assign resp_ok = (state_q == StWait) && inputReady && !redirect;

`ifdef INST_FETCH_BYPASS_EN
  assign bypass_vld = q_empty && resp_ok;
`else
  assign bypass_vld = 1'b0;
`endif

  always_comb begin
    inst_valid = !q_empty || bypass_vld;
    inst       = bypass_vld ? data     : q_rdata[WORD_SIZE +: WORD_SIZE];
    inst_pc    = bypass_vld ? req_pc_q : q_rdata[WORD_SIZE-1:0];
    take       = inst_valid && inst_ready && !redirect;
    q_pop      = take && !q_empty;
    // A bypassed response consumed this cycle never enters the queue.
    q_push     = resp_ok && !(bypass_vld && inst_ready);
    occ_next   = q_count + CntW'(q_push) - CntW'(q_pop);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    num_inst_d = num_inst_q + WORD_SIZE'(take);
    readM      = 1'b0;
    address    = fetch_pc_q;
    unique case (state_q)
      StIdle: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          req_pc_d   = redirect_pc;
          state_d    = StWait;
        end else if (!q_full || q_pop) begin
          // A pop this cycle frees a slot, so the refill starts right away.
          req_pc_d = fetch_pc_q;
          state_d  = StWait;
        end
      end
      StWait: begin
        readM   = 1'b1;
        address = req_pc_q;
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (inputReady) req_pc_d = redirect_pc;
          else            state_d  = StDiscard;
        end else if (inputReady) begin
          fetch_pc_d = req_pc_q + WORD_SIZE'(1);
          req_pc_d   = req_pc_q + WORD_SIZE'(1);
          if (occ_next >= DepthCnt) state_d = StIdle;
        end
      end
      StDiscard: begin
        // Keep presenting the abandoned request until memory completes it.
        readM   = 1'b1;
        address = req_pc_q;
        if (redirect) fetch_pc_d = redirect_pc;
        if (inputReady) begin
          req_pc_d = redirect ? redirect_pc : fetch_pc_q;
          state_d  = StWait;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      num_inst_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      num_inst_q <= num_inst_d;
    end
  end

  assign num_inst  = num_inst_q;
  assign occupancy = q_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  localparam int unsigned D     = 4;
  localparam logic [15:0] RstPc = 16'h0000;
  localparam logic [15:0] Key   = 16'hA5C3;

  logic        clk = 1'b0;
  logic        reset, readM, inputReady, inst_valid, inst_ready, redirect;
  logic [15:0] address, data, inst, inst_pc, redirect_pc, num_inst;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .WORD_SIZE (16),
    .DEPTH     (D),
    .RESET_PC  (RstPc)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .readM       (readM),
    .address     (address),
    .data        (data),
    .inputReady  (inputReady),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .num_inst    (num_inst),
    .occupancy   (occupancy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of {inst, pc} the DUT must deliver, in order.
  logic [31:0] exp_q[$];

  bit          rst_drv, ready_drv, redir_drv, mem_en;
  logic [15:0] redir_pc_drv;
  int          mem_lat, wait_cnt, num_model;
  bit          discard_pend, last_acc_valid;
  logic [15:0] last_acc_addr;
  bit          chk_redir_addr, chk_redir_pc;
  logic [15:0] redir_target;
  logic        g_readm;
  logic [15:0] g_addr;

  // One clock: sample registered outputs, play memory, drive, update model.
  task automatic step();
    logic        ir;
    logic [31:0] e;
    @(negedge clk);
    g_readm = readM;
    g_addr  = address;
    check_eq("occupancy", 32'(occupancy), 32'(exp_q.size()));
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
    check_eq("num_inst", 32'(num_inst), 32'(num_model[15:0]));
    if (last_acc_valid) begin
      if (g_readm) check_eq("next_addr", 32'(g_addr), 32'(16'(last_acc_addr + 16'd1)));
      if (exp_q.size() < D) check_eq("b2b_readm", 32'(g_readm), 32'd1);
      last_acc_valid = 0;
    end
    ir = 1'b0;
    if (g_readm && mem_en) begin
      if (wait_cnt >= mem_lat) begin
        ir = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else if (!g_readm) begin
      wait_cnt = 0;
    end
    inputReady  = ir;
    data        = ir ? (g_addr ^ Key) : 16'($urandom);
    reset       = rst_drv;
    inst_ready  = ready_drv;
    redirect    = redir_drv;
    redirect_pc = redir_drv ? redir_pc_drv : 16'($urandom);
    #1;
    if (rst_drv) begin
      exp_q.delete();
      num_model    = 0;
      discard_pend = 0;
    end else if (redir_drv) begin
      exp_q.delete();
      if (g_readm) discard_pend = !ir;
    end else begin
      if (inst_valid && ready_drv) begin
        if (exp_q.size() == 0) begin
          check_eq("pop_underflow", 32'(inst_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("inst", 32'(inst), 32'(e[31:16]));
          check_eq("inst_pc", 32'(inst_pc), 32'(e[15:0]));
          if (chk_redir_pc) begin
            check_eq("first_pc_after_redir", 32'(inst_pc), 32'(redir_target));
            chk_redir_pc = 0;
          end
          num_model++;
        end
      end
      if (ir) begin
        if (discard_pend) begin
          discard_pend = 0;
        end else begin
          exp_q.push_back({g_addr ^ Key, g_addr});
          last_acc_valid = 1;
          last_acc_addr  = g_addr;
          if (chk_redir_addr) begin
            check_eq("first_addr_after_redir", 32'(g_addr), 32'(redir_target));
            chk_redir_addr = 0;
          end
        end
      end
    end
  endtask

  task automatic do_redirect(input logic [15:0] pc);
    redir_drv    = 1;
    redir_pc_drv = pc;
    step();
    redir_drv    = 0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; inputReady = 1'b0; data = '0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    rst_drv = 1; ready_drv = 0; redir_drv = 0; redir_pc_drv = '0;
    mem_en = 1; mem_lat = 0; wait_cnt = 0; num_model = 0;
    discard_pend = 0; last_acc_valid = 0; last_acc_addr = '0;
    chk_redir_addr = 0; chk_redir_pc = 0; redir_target = '0;

    // Reset values, then the first request.
    repeat (3) step();
    rst_drv = 0;
    step();
    check_eq("rst_readm", 32'(g_readm), 32'd0);
    check_eq("rst_addr", 32'(g_addr), 32'(RstPc));
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_num", 32'(num_inst), 32'd0);
    step();
    check_eq("first_readm", 32'(g_readm), 32'd1);
    check_eq("first_addr", 32'(g_addr), 32'(RstPc));

    // Back-to-back streaming with decode always ready.
    ready_drv = 1;
    repeat (20) step();
    check_eq("b2b_progress", 32'(num_inst >= 16'd16), 32'd1);

    // Fill the queue with decode stalled.
    rst_drv = 1; step(); rst_drv = 0;
    ready_drv = 0; mem_lat = 1;
    repeat (12) step();
    check_eq("full_occ", 32'(occupancy), 32'(D));
    check_eq("full_readm", 32'(g_readm), 32'd0);
    ready_drv = 1; step(); ready_drv = 0;
    step();
    check_eq("refill_readm", 32'(g_readm), 32'd1);
    check_eq("refill_addr", 32'(g_addr), 32'd4);
    repeat (6) step();
    check_eq("full2_occ", 32'(occupancy), 32'(D));
    check_eq("full2_readm", 32'(g_readm), 32'd0);

    // Redirect from IDLE.
    do_redirect(16'h0200);
    step();
    check_eq("idle_redir_readm", 32'(g_readm), 32'd1);
    check_eq("idle_redir_addr", 32'(g_addr), 32'h0200);
    check_eq("idle_redir_occ", 32'(occupancy), 32'd0);

    // Redirect while a read is outstanding and unanswered.
    mem_en = 0; ready_drv = 1;
    step();
    do_redirect(16'h0040);
    step();
    check_eq("disc_readm", 32'(g_readm), 32'd1);
    check_eq("disc_addr_hold", 32'(g_addr), 32'h0200);
    check_eq("disc_occ", 32'(occupancy), 32'd0);
    redir_target = 16'h0040; chk_redir_addr = 1; chk_redir_pc = 1;
    mem_en = 1;
    repeat (8) step();
    check_eq("redir_seen", 32'(chk_redir_addr | chk_redir_pc), 32'd0);

    // Redirect coinciding with a response.
    mem_lat = 0;
    repeat (3) step();
    do_redirect(16'h0100);
    step();
    check_eq("redir_ir_readm", 32'(g_readm), 32'd1);
    check_eq("redir_ir_addr", 32'(g_addr), 32'h0100);
    check_eq("redir_ir_occ", 32'(occupancy), 32'd0);

    // Fetch PC wrap at the top of the address space.
    repeat (2) step();
    do_redirect(16'hFFFF);
    redir_target = 16'hFFFF; chk_redir_addr = 1; chk_redir_pc = 1;
    repeat (5) step();
    check_eq("wrap_seen", 32'(chk_redir_addr | chk_redir_pc), 32'd0);

    // Reset while waiting with two entries queued.
    ready_drv = 0;
    do_redirect(16'h0300);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (occupancy == 3'd2 && readM) found = 1;
    end
    if (!found) check_eq("rst_setup_occ", 32'(occupancy), 32'd2);
    rst_drv = 1; step(); rst_drv = 0;
    step();
    check_eq("rst_mid_readm", 32'(g_readm), 32'd0);
    check_eq("rst_mid_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_mid_num", 32'(num_inst), 32'd0);
    check_eq("rst_mid_addr", 32'(g_addr), 32'(RstPc));
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
